// File: rtl/scope_acq_ctrl.sv
// scope_acq_ctrl
//   Acquisition/trigger sequencer. Decimates the ADC sample stream, writes
//   samples into the circular display buffer, finds the trigger point, keeps
//   pre- and post-trigger samples, and hands a full frame to the renderer.
//
// Ports
//   clk, rst          system clock; asynchronous reset, active-low
//   sample_in         raw unsigned sample, valid every cycle
//   sample_div        one sample every sample_div clocks (0 behaves as 1)
//   trig_level        trigger threshold
//   trig_rising       1 = rising edge, 0 = falling edge
//   trig_mode         0 AUTO, 1 NORMAL, 2 SINGLE, 3 NORMAL
//   pretrig           samples kept ahead of the trigger
//   arm, stop         1-cycle pulses: start acquisition / abort to IDLE
//   force_trig        1-cycle pulse: force a trigger while waiting
//                     (named force_trig because "force" is a reserved word)
//   disp_busy         renderer is reading the buffer; blocks auto rearm
//   wr_en/addr/data   buffer write port
//   trig_addr         address of the trigger sample
//   start_addr        oldest sample of the frame (trig_addr - pretrig)
//   buf_valid         a complete frame is in the buffer
//   triggered         last frame came from a real edge
//   state             current sequencer state
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE  (0) | stopped, waiting for arm
// PRE   (1) | filling the pre-trigger samples
// WAIT  (2) | writing continuously, looking for a trigger
// POST  (3) | filling the post-trigger samples
// DONE  (4) | frame complete, buf_valid high, waiting to rearm

module scope_acq_ctrl #(
  parameter int DW      = 8,
  parameter int AW      = 9,
  parameter int DIV_W   = 24,
  parameter int AUTO_TO = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    sample_in,
  input  logic [DIV_W-1:0] sample_div,
  input  logic [DW-1:0]    trig_level,
  input  logic             trig_rising,
  input  logic [1:0]       trig_mode,
  input  logic [AW-1:0]    pretrig,
  input  logic             arm,
  input  logic             stop,
  input  logic             force_trig,
  input  logic             disp_busy,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic [AW-1:0]    trig_addr,
  output logic [AW-1:0]    start_addr,
  output logic             buf_valid,
  output logic             triggered,
  output logic [2:0]       state
);

  localparam int AT_W = $clog2(AUTO_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    pre_lat;
  logic [AW-1:0]    pre_rem;
  logic [AW-1:0]    post_rem;
  logic [AT_W-1:0]  auto_rem;
  logic [DW-1:0]    prev;
  logic             prev_valid;
  logic             force_pend;

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]   cnt_nxt;
  logic             strobe;
  logic             edge_hit;
  logic             auto_hit;

  always_comb begin
    div_eff  = (sample_div == '0) ? DIV_W'(1) : sample_div;
    cnt_nxt  = {1'b0, div_cnt} + (DIV_W+1)'(1);
    // ">=" so that shrinking sample_div mid-period still yields a strobe
    strobe   = (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST) &&
               (cnt_nxt >= {1'b0, div_eff});
    edge_hit = prev_valid &&
               (trig_rising ? (prev < trig_level && sample_in >= trig_level)
                            : (prev > trig_level && sample_in <= trig_level));
    auto_hit = (trig_mode == 2'd0) && (auto_rem == '0);
  end

  assign state = state_q;

  // pretrig is AW bits wide, so it can never exceed DEPTH-1; no clamp needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_cnt    <= '0;
      ptr        <= '0;
      pre_lat    <= '0;
      pre_rem    <= '0;
      post_rem   <= '0;
      auto_rem   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      buf_valid  <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (strobe) begin
        prev       <= sample_in;
        prev_valid <= 1'b1;
        div_cnt    <= '0;
      end else if (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST) begin
        div_cnt <= cnt_nxt[DIV_W-1:0];
      end

      if (stop) begin
        state_q    <= S_IDLE;
        buf_valid  <= 1'b0;
        force_pend <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arm) begin
              state_q    <= S_PRE;
              div_cnt    <= '0;
              pre_lat    <= pretrig;
              pre_rem    <= pretrig;
              prev_valid <= 1'b0;
            end
          end
          S_PRE: begin
            if (pre_rem == '0) begin
              state_q    <= S_WAIT;
              auto_rem   <= AT_W'(AUTO_TO - 1);
              force_pend <= 1'b0;
            end else if (strobe) begin
              wr_en   <= 1'b1;
              wr_data <= sample_in;
              wr_addr <= ptr;
              ptr     <= ptr + AW'(1);
              pre_rem <= pre_rem - AW'(1);
              if (pre_rem == AW'(1)) begin
                state_q    <= S_WAIT;
                auto_rem   <= AT_W'(AUTO_TO - 1);
                force_pend <= 1'b0;
              end
            end
          end
          S_WAIT: begin
            if (strobe) begin
              wr_en   <= 1'b1;
              wr_data <= sample_in;
              wr_addr <= ptr;
              ptr     <= ptr + AW'(1);
              // a force only counts on a strobe strictly after its pulse
              if (edge_hit || force_pend || auto_hit) begin
                trig_addr  <= ptr;
                start_addr <= ptr - pre_lat;
                triggered  <= edge_hit;
                post_rem   <= {AW{1'b1}} - pre_lat;
                force_pend <= 1'b0;
                state_q    <= S_POST;
              end else begin
                if (auto_rem != '0) auto_rem <= auto_rem - AT_W'(1);
                if (force_trig) force_pend <= 1'b1;
              end
            end else if (force_trig) begin
              force_pend <= 1'b1;
            end
          end
          S_POST: begin
            if (post_rem == '0) begin
              state_q   <= S_DONE;
              buf_valid <= 1'b1;
            end else if (strobe) begin
              wr_en    <= 1'b1;
              wr_data  <= sample_in;
              wr_addr  <= ptr;
              ptr      <= ptr + AW'(1);
              post_rem <= post_rem - AW'(1);
              if (post_rem == AW'(1)) begin
                state_q   <= S_DONE;
                buf_valid <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (arm || (trig_mode != 2'd2 && !disp_busy)) begin
              state_q    <= S_PRE;
              buf_valid  <= 1'b0;
              div_cnt    <= '0;
              pre_lat    <= pretrig;
              pre_rem    <= pretrig;
              prev_valid <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
